// File: rtl/meas_sequencer_pkg.sv
// Shared types and constants for the periodic measurement sequencer.
//   state_e      : sequencer FSM state encoding
//   REG_PTR_TEMP : sensor pointer byte written before every read-back
//   LEN_PTR      : byte count of the pointer write
//   LEN_RD       : byte count of the result read (temp MSB/LSB, hum MSB/LSB)
//   cnt_width()  : bits needed to hold a counter value 0..max_val
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PTR_REQ  = 3'd1,
    ST_PTR_WAIT = 3'd2,
    ST_CONV     = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_UPDATE   = 3'd6,
    ST_BACKOFF  = 3'd7
  } state_e;

  localparam logic [7:0] REG_PTR_TEMP = 8'h00;
  localparam logic [2:0] LEN_PTR      = 3'd1;
  localparam logic [2:0] LEN_RD       = 3'd4;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/meas_sequencer_tick_gen.sv
// Free-running period counter for the measurement trigger.
//   clk100MHz : system clock
//   rst       : synchronous active-high reset (counter restarts at 0)
//   tick      : high for one cycle when the counter wraps (PERIOD_CYCLES-1 -> 0)
module tick_gen
  import meas_pkg::*;
#(
  parameter int PERIOD_CYCLES = 100_000_000
) (
  input  logic clk100MHz,
  input  logic rst,
  output logic tick
);

  localparam int CW = cnt_width(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/meas_sequencer.sv
// Periodic temperature/humidity measurement controller in front of a
// transaction-level I2C engine.
//   clk100MHz, rst       : clock, synchronous active-high reset
//   disp_sel             : 0 = temperature, 1 = humidity on data_out
//   txn_req/rw/addr/     : registered one-cycle request to the engine
//   txn_wdata/txn_len
//   txn_busy/done/nack/  : engine status and read data (rdata valid on done)
//   txn_rdata
//   temp_raw, hum_raw    : last good result words
//   data_out             : selected result word (combinational mux)
//   meas_valid           : one-cycle pulse, coincides with new raw values
//   stale, err_count     : abandoned-measurement status
//   busy                 : sequencer not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a pending trigger
// PTR_REQ  | issue pointer write once the engine is free
// PTR_WAIT | wait for pointer write completion / timeout
// CONV     | sensor conversion wait (CONV_CYCLES)
// RD_REQ   | issue 4-byte read once the engine is free
// RD_WAIT  | wait for read completion / timeout
// UPDATE   | one cycle, results already latched, meas_valid high
// BACKOFF  | pause before retrying from the pointer write
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int         PERIOD_CYCLES  = 100_000_000,
  parameter int         CONV_CYCLES    = 1_500_000,
  parameter int         TIMEOUT_CYCLES = 200_000,
  parameter int         BACKOFF_CYCLES = 100_000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [6:0] SENSOR_ADDR    = 7'h40
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        disp_sel,
  output logic        txn_req,
  output logic        txn_rw,
  output logic [6:0]  txn_addr,
  output logic [7:0]  txn_wdata,
  output logic [2:0]  txn_len,
  input  logic        txn_busy,
  input  logic        txn_done,
  input  logic        txn_nack,
  input  logic [31:0] txn_rdata,
  output logic [15:0] temp_raw,
  output logic [15:0] hum_raw,
  output logic [15:0] data_out,
  output logic        meas_valid,
  output logic        stale,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int WAIT_MAX = (CONV_CYCLES > BACKOFF_CYCLES) ? CONV_CYCLES : BACKOFF_CYCLES;
  localparam int WW = cnt_width(WAIT_MAX);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int RW = cnt_width(MAX_RETRY);

  localparam logic [WW-1:0] CONV_LOAD    = WW'(CONV_CYCLES - 1);
  localparam logic [WW-1:0] BACKOFF_LOAD = WW'(BACKOFF_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD     = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  logic          tick;
  logic          pending_q, pending_d;
  logic [WW-1:0] wait_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;
  logic          txn_req_q, txn_rw_q;
  logic [7:0]    txn_wdata_q;
  logic [2:0]    txn_len_q;
  logic [15:0]   temp_q, hum_q;
  logic          meas_valid_q, stale_q;
  logic [7:0]    err_q;

  logic start, issue, in_wait, timed_out, done_ok, attempt_fail, can_retry, wait_end;

  tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick_gen (
    .clk100MHz(clk100MHz),
    .rst      (rst),
    .tick     (tick)
  );

  // Events derived from the current state; done/nack are only honoured in
  // the two WAIT states, and an expired timeout masks a same-cycle done.
  always_comb begin
    start        = (state_q == ST_IDLE) && pending_q;
    issue        = ((state_q == ST_PTR_REQ) || (state_q == ST_RD_REQ)) && !txn_busy;
    in_wait      = (state_q == ST_PTR_WAIT) || (state_q == ST_RD_WAIT);
    timed_out    = in_wait && (tmo_q == '0);
    done_ok      = in_wait && !timed_out && txn_done && !txn_nack;
    attempt_fail = in_wait && (timed_out || (txn_done && txn_nack));
    can_retry    = (retry_q < RETRY_MAX);
    wait_end     = (wait_q == '0);
    // A tick in the same cycle as the IDLE consume keeps pending set.
    pending_d    = tick ? 1'b1 : (start ? 1'b0 : pending_q);
  end

  // State register
  always_ff @(posedge clk100MHz) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (pending_q) state_d = ST_PTR_REQ;
      ST_PTR_REQ:  if (!txn_busy) state_d = ST_PTR_WAIT;
      ST_PTR_WAIT: begin
        if (done_ok)           state_d = ST_CONV;
        else if (attempt_fail) state_d = can_retry ? ST_BACKOFF : ST_IDLE;
      end
      ST_CONV:     if (wait_end) state_d = ST_RD_REQ;
      ST_RD_REQ:   if (!txn_busy) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (done_ok)           state_d = ST_UPDATE;
        else if (attempt_fail) state_d = can_retry ? ST_BACKOFF : ST_IDLE;
      end
      ST_UPDATE:   state_d = ST_IDLE;
      ST_BACKOFF:  if (wait_end) state_d = ST_PTR_REQ;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != ST_IDLE);
    txn_req    = txn_req_q;
    txn_rw     = txn_rw_q;
    txn_addr   = SENSOR_ADDR;
    txn_wdata  = txn_wdata_q;
    txn_len    = txn_len_q;
    temp_raw   = temp_q;
    hum_raw    = hum_q;
    data_out   = disp_sel ? hum_q : temp_q;
    meas_valid = meas_valid_q;
    stale      = stale_q;
    err_count  = err_q;
  end

  // Counters, request registers and result registers
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      pending_q    <= 1'b1;
      wait_q       <= '0;
      tmo_q        <= '0;
      retry_q      <= '0;
      txn_req_q    <= 1'b0;
      txn_rw_q     <= 1'b0;
      txn_wdata_q  <= 8'h00;
      txn_len_q    <= 3'd0;
      temp_q       <= 16'h0000;
      hum_q        <= 16'h0000;
      meas_valid_q <= 1'b0;
      stale_q      <= 1'b0;
      err_q        <= 8'h00;
    end else begin
      pending_q <= pending_d;

      txn_req_q <= issue;
      if (issue) begin
        txn_rw_q    <= (state_q == ST_RD_REQ);
        txn_len_q   <= (state_q == ST_RD_REQ) ? LEN_RD : LEN_PTR;
        txn_wdata_q <= REG_PTR_TEMP;
      end

      // Timeout is a down-counter armed with each request.
      if (issue)                        tmo_q <= TMO_LOAD;
      else if (in_wait && !timed_out)   tmo_q <= tmo_q - 1'b1;

      if ((state_q == ST_PTR_WAIT) && done_ok)
        wait_q <= CONV_LOAD;
      else if (attempt_fail && can_retry)
        wait_q <= BACKOFF_LOAD;
      else if (((state_q == ST_CONV) || (state_q == ST_BACKOFF)) && !wait_end)
        wait_q <= wait_q - 1'b1;

      if (start)                          retry_q <= '0;
      else if (attempt_fail && can_retry) retry_q <= retry_q + 1'b1;

      // Results are captured on the accepted read completion so they are
      // visible during UPDATE together with meas_valid.
      meas_valid_q <= (state_q == ST_RD_WAIT) && done_ok;
      if ((state_q == ST_RD_WAIT) && done_ok) begin
        temp_q  <= txn_rdata[31:16];
        hum_q   <= txn_rdata[15:0];
        stale_q <= 1'b0;
      end else if (attempt_fail && !can_retry) begin
        stale_q <= 1'b1;
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
module tb_meas_sequencer;

  logic        clk100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        disp_sel = 1'b0;
  logic        txn_busy = 1'b0;
  logic        txn_done = 1'b0;
  logic        txn_nack = 1'b0;
  logic [31:0] txn_rdata = 32'h0;
  logic        txn_req, txn_rw;
  logic [6:0]  txn_addr;
  logic [7:0]  txn_wdata;
  logic [2:0]  txn_len;
  logic [15:0] temp_raw, hum_raw, data_out;
  logic        meas_valid, stale, busy;
  logic [7:0]  err_count;

  int checks = 0;
  int fails  = 0;

  meas_sequencer #(
    .PERIOD_CYCLES (1000),
    .CONV_CYCLES   (100),
    .TIMEOUT_CYCLES(50),
    .BACKOFF_CYCLES(20),
    .MAX_RETRY     (2),
    .SENSOR_ADDR   (7'h40)
  ) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .disp_sel  (disp_sel),
    .txn_req   (txn_req),
    .txn_rw    (txn_rw),
    .txn_addr  (txn_addr),
    .txn_wdata (txn_wdata),
    .txn_len   (txn_len),
    .txn_busy  (txn_busy),
    .txn_done  (txn_done),
    .txn_nack  (txn_nack),
    .txn_rdata (txn_rdata),
    .temp_raw  (temp_raw),
    .hum_raw   (hum_raw),
    .data_out  (data_out),
    .meas_valid(meas_valid),
    .stale     (stale),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk100MHz = ~clk100MHz;

  // Returns at the negedge where txn_req is seen; n = negedges waited, -1 if none.
  task automatic wait_req(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk100MHz);
      if (txn_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called at the request negedge; completion pulse lat cycles later.
  task automatic engine_done(input int lat, input logic nack, input logic [31:0] data);
    repeat (lat) @(negedge clk100MHz);
    txn_done  = 1'b1;
    txn_nack  = nack;
    txn_rdata = data;
    @(negedge clk100MHz);
    txn_done = 1'b0;
    txn_nack = 1'b0;
  endtask

  // Returns at the negedge where rst drops (cycle 0).
  task automatic do_reset();
    rst = 1'b1; txn_done = 1'b0; txn_nack = 1'b0; disp_sel = 1'b0;
    repeat (3) @(negedge clk100MHz);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk100MHz);
    checks++; if (txn_req !== 1'b0) begin fails++; $display("FAIL reset_txn_req got %0h want 0", txn_req); end
    checks++; if (txn_rw !== 1'b0) begin fails++; $display("FAIL reset_txn_rw got %0h want 0", txn_rw); end
    checks++; if (txn_wdata !== 8'h00) begin fails++; $display("FAIL reset_txn_wdata got %0h want 00", txn_wdata); end
    checks++; if (txn_len !== 3'd0) begin fails++; $display("FAIL reset_txn_len got %0d want 0", txn_len); end
    checks++; if (temp_raw !== 16'h0) begin fails++; $display("FAIL reset_temp got %0h want 0", temp_raw); end
    checks++; if (hum_raw !== 16'h0) begin fails++; $display("FAIL reset_hum got %0h want 0", hum_raw); end
    checks++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL reset_meas_valid got %0h want 0", meas_valid); end
    checks++; if (stale !== 1'b0) begin fails++; $display("FAIL reset_stale got %0h want 0", stale); end
    checks++; if (err_count !== 8'h0) begin fails++; $display("FAIL reset_err got %0h want 0", err_count); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0h want 0", busy); end
    rst = 1'b0;
    @(negedge clk100MHz);
    checks++; if (busy !== 1'b1 || txn_req !== 1'b0) begin fails++; $display("FAIL reset_cycle1 busy=%0h req=%0h want busy=1 req=0", busy, txn_req); end
    @(negedge clk100MHz);
    checks++; if (txn_req !== 1'b1) begin fails++; $display("FAIL reset_first_req got %0h want 1", txn_req); end
  endtask

  task automatic test_clean();
    int n;
    do_reset();
    wait_req(10, n);
    checks++; if (n != 2) begin fails++; $display("FAIL clean_ptr_latency got %0d want 2", n); end
    checks++; if (txn_rw !== 1'b0 || txn_len !== 3'd1) begin fails++; $display("FAIL clean_ptr_cmd rw=%0h len=%0d want rw=0 len=1", txn_rw, txn_len); end
    checks++; if (txn_addr !== 7'h40 || txn_wdata !== 8'h00) begin fails++; $display("FAIL clean_ptr_addr addr=%0h wdata=%0h want 40/00", txn_addr, txn_wdata); end
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    checks++; if (n != 101) begin fails++; $display("FAIL clean_conv_wait got %0d want 101", n); end
    checks++; if (txn_rw !== 1'b1 || txn_len !== 3'd4) begin fails++; $display("FAIL clean_rd_cmd rw=%0h len=%0d want rw=1 len=4", txn_rw, txn_len); end
    engine_done(10, 1'b0, 32'h6640_8000);
    checks++; if (meas_valid !== 1'b1) begin fails++; $display("FAIL clean_meas_valid got %0h want 1", meas_valid); end
    checks++; if (temp_raw !== 16'h6640 || hum_raw !== 16'h8000) begin fails++; $display("FAIL clean_raw temp=%0h hum=%0h want 6640/8000", temp_raw, hum_raw); end
    checks++; if (data_out !== 16'h6640) begin fails++; $display("FAIL clean_data_out_temp got %0h want 6640", data_out); end
    checks++; if (stale !== 1'b0) begin fails++; $display("FAIL clean_stale got %0h want 0", stale); end
    @(negedge clk100MHz);
    checks++; if (meas_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL clean_after mv=%0h busy=%0h want 0/0", meas_valid, busy); end
    disp_sel = 1'b1;
    #1;
    checks++; if (data_out !== 16'h8000) begin fails++; $display("FAIL clean_data_out_hum got %0h want 8000", data_out); end
    disp_sel = 1'b0;
  endtask

  task automatic test_nack_retry();
    int n;
    do_reset();
    wait_req(10, n);
    engine_done(10, 1'b1, 32'h0);
    checks++; if (busy !== 1'b1 || txn_req !== 1'b0) begin fails++; $display("FAIL nack_backoff busy=%0h req=%0h want 1/0", busy, txn_req); end
    wait_req(100, n);
    checks++; if (n != 21) begin fails++; $display("FAIL nack_backoff_len got %0d want 21", n); end
    checks++; if (txn_rw !== 1'b0 || txn_len !== 3'd1) begin fails++; $display("FAIL nack_reissue rw=%0h len=%0d want ptr write", txn_rw, txn_len); end
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    checks++; if (n != 101) begin fails++; $display("FAIL nack_conv_wait got %0d want 101", n); end
    engine_done(10, 1'b0, 32'h1234_5678);
    checks++; if (meas_valid !== 1'b1 || temp_raw !== 16'h1234 || hum_raw !== 16'h5678) begin fails++; $display("FAIL nack_result mv=%0h temp=%0h hum=%0h want 1/1234/5678", meas_valid, temp_raw, hum_raw); end
    checks++; if (stale !== 1'b0 || err_count !== 8'h0) begin fails++; $display("FAIL nack_status stale=%0h err=%0d want 0/0", stale, err_count); end
  endtask

  task automatic test_exhausted();
    int n;
    do_reset();
    wait_req(10, n);
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    engine_done(10, 1'b0, 32'hABCD_0123);
    wait_req(1000, n);
    checks++; if (n != 877) begin fails++; $display("FAIL exh_period_start got %0d want 877", n); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_req(100, n);
        checks++; if (n != 21) begin fails++; $display("FAIL exh_retry%0d got %0d want 21", i, n); end
      end
      checks++; if (txn_rw !== 1'b0) begin fails++; $display("FAIL exh_ptr%0d rw got %0h want 0", i, txn_rw); end
      engine_done(10, 1'b1, 32'h0);
    end
    checks++; if (stale !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL exh_status stale=%0h err=%0d want 1/1", stale, err_count); end
    checks++; if (busy !== 1'b0 || meas_valid !== 1'b0) begin fails++; $display("FAIL exh_idle busy=%0h mv=%0h want 0/0", busy, meas_valid); end
    checks++; if (temp_raw !== 16'hABCD || hum_raw !== 16'h0123) begin fails++; $display("FAIL exh_raw_hold temp=%0h hum=%0h want ABCD/0123", temp_raw, hum_raw); end
    wait_req(100, n);
    checks++; if (n != -1) begin fails++; $display("FAIL exh_fourth_write seen at %0d want none", n); end
  endtask

  task automatic test_timeout();
    int n;
    int first;
    do_reset();
    wait_req(10, n);
    checks++; if (n != 2) begin fails++; $display("FAIL tmo_first_req got %0d want 2", n); end
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk100MHz);
      if (txn_req === 1'b1) begin
        first = k;
        break;
      end
      txn_done = (k == 60);
    end
    txn_done = 1'b0;
    checks++; if (first != 72) begin fails++; $display("FAIL tmo_retry_req got %0d want 72", first); end
    engine_done(49, 1'b0, 32'h0);
    wait_req(200, n);
    checks++; if (n != 101) begin fails++; $display("FAIL tmo_done_at_49 got %0d want 101", n); end
  endtask

  task automatic test_overrun();
    int n;
    int reqs;
    txn_busy = 1'b1;
    do_reset();
    reqs = 0;
    for (int i = 1; i <= 2500; i++) begin
      @(negedge clk100MHz);
      if (txn_req === 1'b1) reqs++;
    end
    checks++; if (reqs != 0) begin fails++; $display("FAIL ovr_req_while_busy got %0d want 0", reqs); end
    txn_busy = 1'b0;
    wait_req(10, n);
    checks++; if (n != 1) begin fails++; $display("FAIL ovr_release_req got %0d want 1", n); end
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    engine_done(10, 1'b0, 32'h1111_2222);
    checks++; if (meas_valid !== 1'b1 || temp_raw !== 16'h1111) begin fails++; $display("FAIL ovr_first_meas mv=%0h temp=%0h want 1/1111", meas_valid, temp_raw); end
    wait_req(20, n);
    checks++; if (n != 3) begin fails++; $display("FAIL ovr_pending_start got %0d want 3", n); end
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    engine_done(10, 1'b0, 32'h3333_4444);
    wait_req(400, n);
    checks++; if (n != 252) begin fails++; $display("FAIL ovr_next_tick got %0d want 252", n); end
  endtask

  task automatic test_reset_rd_wait();
    int n;
    engine_done(10, 1'b0, 32'h0);
    wait_req(200, n);
    checks++; if (n != 101 || txn_rw !== 1'b1) begin fails++; $display("FAIL rst_reach_rd n=%0d rw=%0h want 101/1", n, txn_rw); end
    repeat (5) @(negedge clk100MHz);
    rst = 1'b1;
    @(negedge clk100MHz);
    checks++; if (temp_raw !== 16'h0 || hum_raw !== 16'h0 || data_out !== 16'h0) begin fails++; $display("FAIL rst_raw temp=%0h hum=%0h out=%0h want 0", temp_raw, hum_raw, data_out); end
    checks++; if (busy !== 1'b0 || txn_req !== 1'b0 || txn_rw !== 1'b0 || txn_len !== 3'd0) begin fails++; $display("FAIL rst_ctrl busy=%0h req=%0h rw=%0h len=%0d want 0", busy, txn_req, txn_rw, txn_len); end
    checks++; if (meas_valid !== 1'b0 || stale !== 1'b0 || err_count !== 8'h0) begin fails++; $display("FAIL rst_status mv=%0h stale=%0h err=%0d want 0", meas_valid, stale, err_count); end
    rst = 1'b0;
    @(negedge clk100MHz);
    txn_done = 1'b1;
    @(negedge clk100MHz);
    txn_done = 1'b0;
    checks++; if (txn_req !== 1'b1 || txn_rw !== 1'b0 || txn_len !== 3'd1) begin fails++; $display("FAIL rst_new_ptr req=%0h rw=%0h len=%0d want 1/0/1", txn_req, txn_rw, txn_len); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_nack_retry();
    test_exhausted();
    test_timeout();
    test_overrun();
    test_reset_rd_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
